// File: rtl/onehot_strobe_decoder_pkg.sv
// decoder_defs: shared definitions for the one-hot strobe decoder.
//   state_t             FSM state encodings (IDLE / HOLD / GAP)
//   CNT_W               width of the shared HOLD/GAP down-counter
//   HOLD_*/GAP_* limits legal parameter ranges, checked at elaboration
package decoder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int CNT_W    = 8;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;
  localparam int GAP_MIN  = 0;
  localparam int GAP_MAX  = 255;

endpackage

// File: rtl/onehot_strobe_decoder_dec3x8.sv
// onehot_dec3x8: purely combinational 3-bit binary to 8-bit one-hot decoder.
//   code    in  3  binary line index
//   onehot  out 8  exactly one bit set, bit position = code
module onehot_dec3x8 (
  input  logic [2:0] code,
  output logic [7:0] onehot
);

  for (genvar i = 0; i < 8; i++) begin : g_line
    assign onehot[i] = (code == 3'(i));
  end

endmodule

// File: rtl/onehot_strobe_decoder.sv
// onehot_strobe_decoder: accepts a 3-bit code over valid/ready and drives the
// matching one-hot strobe for HOLD_CYCLES cycles, then GAP_CYCLES of zero.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     code present on in_code
//   in_ready     high in IDLE only
//   in_code      binary line index, sampled at the transfer edge only
//   in_parity    even parity over in_code      (DEC_PARITY_EN builds only)
//   err          one-cycle bad-parity pulse    (DEC_PARITY_EN builds only)
//   out          registered one-hot strobe, zero when idle
//   out_valid    registered, high exactly while out is non-zero
//   busy         high in HOLD or GAP
// Optional feature macro: DEC_PARITY_EN.
module onehot_strobe_decoder
  import decoder_defs::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
`ifdef DEC_PARITY_EN
  input  logic       in_parity,
  output logic       err,
`endif
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  if (HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
    $error("onehot_strobe_decoder: HOLD_CYCLES out of range 1..255");
  end
  if (GAP_CYCLES < GAP_MIN || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
    $error("onehot_strobe_decoder: GAP_CYCLES out of range 0..255");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  // Only used when GAP_CYCLES > 0; guarded below so the wrap at 0 is harmless.
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       out_nxt;
  logic             out_valid_nxt;
  logic [7:0]       dec;
  logic             par_bad;

  onehot_dec3x8 u_dec (
    .code   (in_code),
    .onehot (dec)
  );

`ifdef DEC_PARITY_EN
  logic err_nxt;
  assign par_bad = ^{in_code, in_parity};
`else
  assign par_bad = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef DEC_PARITY_EN
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
`ifdef DEC_PARITY_EN
      err       <= err_nxt;
`endif
    end
  end

  // Next-state / next-register logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    out_nxt       = out;
    out_valid_nxt = out_valid;
`ifdef DEC_PARITY_EN
    err_nxt       = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          // Bad parity still completes the handshake; it just issues no strobe.
          if (par_bad) begin
`ifdef DEC_PARITY_EN
            err_nxt = 1'b1;
`endif
          end else begin
            out_nxt       = dec;
            out_valid_nxt = 1'b1;
            cnt_nxt       = HOLD_LOAD;
            state_nxt     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          out_nxt       = '0;
          out_valid_nxt = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt   = GAP_LOAD;
            state_nxt = ST_GAP;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt     = ST_IDLE;
        cnt_nxt       = '0;
        out_nxt       = '0;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Handshake / status outputs decoded from the state register
  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

endmodule
